// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and helpers for the multi-port register file
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Keeps address ports at least one bit wide for a single-entry file.
  function automatic int rf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - post-reset clear sequencer: walks every address once, then reports ready
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = rf_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // The pointer holds at the last address instead of wrapping.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == RF_CLEAR) begin
      if (clr_ptr_q == LAST_ADDR) begin
        state_d = RF_READY;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    clr_we   = (state_q == RF_CLEAR);
    clr_addr = clr_ptr_q;
    ready    = (state_q == RF_READY);
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-read-port register file with post-reset clear
// Optional write-first read bypass is enabled by defining RF_BYPASS_EN.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NREAD    = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = rf_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   ready,
  output logic                   wr_err
);

  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_in_range;
  logic             wr_zero;
  logic             wr_acc;
  logic             wr_err_q, wr_err_d;
  logic [WIDTH-1:0] rf_q [DEPTH];

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign wr_zero     = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_acc      = wr_en && ready && wr_in_range && !wr_zero;
  // A write to a hardwired zero register is dropped silently, not flagged.
  assign wr_err_d    = wr_en && (!ready || !wr_in_range);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

  // Storage carries no reset; the clear sequencer owns the port until ready.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      rf_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic             ra_ok;
    logic [WIDTH-1:0] val;

    assign ra    = rd_addr[k*AW +: AW];
    assign ra_ok = ready && ({1'b0, ra} < DEPTH_X) && !((ZERO_REG != 0) && (ra == '0));
`ifdef RF_BYPASS_EN
    assign val   = (wr_acc && (wr_addr == ra)) ? wr_data : rf_q[ra];
`else
    assign val   = rf_q[ra];
`endif
    assign rd_data[k*WIDTH +: WIDTH] = ra_ok ? val : '0;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp (default build and DEPTH=24/ZERO_REG=0)
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  a_rd_addr, b_rd_addr;
  logic [63:0] a_rd_data, b_rd_data;
  logic        a_wr_en, b_wr_en;
  logic [4:0]  a_wr_addr, b_wr_addr;
  logic [31:0] a_wr_data, b_wr_data;
  logic        a_ready, b_ready, a_wr_err, b_wr_err;

  reg_file_mp u_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .ready(a_ready), .wr_err(a_wr_err)
  );

  reg_file_mp #(.WIDTH(32), .DEPTH(24), .NREAD(2), .ZERO_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .ready(b_ready), .wr_err(b_wr_err)
  );

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t         sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_a [32];
  logic [31:0] m_b [24];
  logic        rdy_a = 1'b0, rdy_b = 1'b0, err_a = 1'b0, err_b = 1'b0;
  int          cnt_a = 0, cnt_b = 0;
  logic [31:0] byp_exp;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      0: return a_rd_data[31:0];
      1: return a_rd_data[63:32];
      2: return b_rd_data[31:0];
      3: return b_rd_data[63:32];
      4: return {31'b0, a_ready};
      5: return {31'b0, a_wr_err};
      6: return {31'b0, b_ready};
      7: return {31'b0, b_wr_err};
      default: return 'x;
    endcase
  endfunction

  task automatic push(int kind, logic [31:0] exp, string tag);
    sb_t e;
    e.kind = kind;
    e.exp  = exp;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] exp_a(logic [4:0] addr);
    if (!rdy_a || addr == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (a_wr_en && a_wr_addr == addr) return a_wr_data;
`endif
    return m_a[addr];
  endfunction

  function automatic logic [31:0] exp_b(logic [4:0] addr);
    if (!rdy_b || addr >= 5'd24) return 32'h0;
`ifdef RF_BYPASS_EN
    if (b_wr_en && b_wr_addr == addr) return b_wr_data;
`endif
    return m_b[int'(addr)];
  endfunction

  task automatic check_sb();
    sb_t         e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.kind);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      cnt_a = 0; rdy_a = 1'b0; err_a = 1'b0;
      cnt_b = 0; rdy_b = 1'b0; err_b = 1'b0;
    end else begin
      err_a = a_wr_en && !rdy_a;
      if (rdy_a && a_wr_en && a_wr_addr != 5'd0) m_a[a_wr_addr] = a_wr_data;
      if (!rdy_a) begin
        cnt_a++;
        if (cnt_a == 32) begin
          rdy_a = 1'b1;
          foreach (m_a[i]) m_a[i] = 32'h0;
        end
      end
      err_b = b_wr_en && (!rdy_b || b_wr_addr >= 5'd24);
      if (rdy_b && b_wr_en && b_wr_addr < 5'd24) m_b[int'(b_wr_addr)] = b_wr_data;
      if (!rdy_b) begin
        cnt_b++;
        if (cnt_b == 24) begin
          rdy_b = 1'b1;
          foreach (m_b[i]) m_b[i] = 32'h0;
        end
      end
    end
  endtask

  task automatic cycle();
    push(4, {31'b0, rdy_a}, "a_ready");
    push(5, {31'b0, err_a}, "a_wr_err");
    push(6, {31'b0, rdy_b}, "b_ready");
    push(7, {31'b0, err_b}, "b_wr_err");
    push(0, exp_a(a_rd_addr[4:0]), "a_rd0");
    push(1, exp_a(a_rd_addr[9:5]), "a_rd1");
    push(2, exp_b(b_rd_addr[4:0]), "b_rd0");
    push(3, exp_b(b_rd_addr[9:5]), "b_rd1");
    @(negedge clk);
    check_sb();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_a(logic we, logic [4:0] wa, logic [31:0] wd, logic [4:0] r0, logic [4:0] r1);
    a_wr_en = we; a_wr_addr = wa; a_wr_data = wd; a_rd_addr = {r1, r0};
  endtask

  task automatic set_b(logic we, logic [4:0] wa, logic [31:0] wd, logic [4:0] r0, logic [4:0] r1);
    b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_rd_addr = {r1, r0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RF_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'h11;
`endif
    rst_n = 1'b0;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    @(posedge clk);
    model_edge();
    #1;
    cycle();

    // Clear sequence after reset release, then every register reads zero.
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_a(0, 0, 0, 5'(i), 5'(31 - i));
      set_b(0, 0, 0, 5'(i), 5'(31 - i));
      push(4, 32'h0, "t1_a_not_ready");
      if (i < 24) push(6, 32'h0, "t1_b_not_ready");
      cycle();
    end
    push(4, 32'h1, "t1_a_ready");
    push(6, 32'h1, "t1_b_ready");
    for (int i = 0; i < 32; i++) begin
      set_a(0, 0, 0, 5'(i), 5'(31 - i));
      set_b(0, 0, 0, 5'(i), 5'(31 - i));
      push(0, 32'h0, "t1_a_zero0");
      push(1, 32'h0, "t1_a_zero1");
      push(2, 32'h0, "t1_b_zero0");
      push(3, 32'h0, "t1_b_zero1");
      cycle();
    end

    // Write then read on both ports.
    set_a(1, 5, 32'hDEADBEEF, 0, 0);
    set_b(1, 5, 32'hCAFEF00D, 0, 0);
    cycle();
    set_a(0, 0, 0, 5, 5);
    set_b(0, 0, 0, 5, 5);
    push(0, 32'hDEADBEEF, "t2_a_rd0");
    push(1, 32'hDEADBEEF, "t2_a_rd1");
    push(2, 32'hCAFEF00D, "t2_b_rd0");
    push(3, 32'hCAFEF00D, "t2_b_rd1");
    cycle();

    // Register 0: hardwired on A, ordinary on B.
    set_a(1, 0, 32'h1234, 0, 0);
    set_b(1, 0, 32'h1234, 0, 0);
    cycle();
    set_a(0, 0, 0, 0, 5);
    set_b(0, 0, 0, 0, 5);
    push(5, 32'h0, "t3_a_no_err");
    push(0, 32'h0, "t3_a_r0_zero");
    push(1, 32'hDEADBEEF, "t3_a_r5_kept");
    push(2, 32'h1234, "t3_b_r0");
    cycle();

    // Same-cycle write and read.
    set_a(1, 7, 32'h11, 1, 2);
    set_b(1, 7, 32'h11, 1, 2);
    cycle();
    set_a(1, 7, 32'h55, 7, 7);
    set_b(1, 7, 32'h55, 7, 7);
    push(0, byp_exp, "t4_a_same_cycle0");
    push(1, byp_exp, "t4_a_same_cycle1");
    push(2, byp_exp, "t4_b_same_cycle");
    cycle();
    set_a(0, 0, 0, 7, 0);
    set_b(0, 0, 0, 7, 0);
    push(0, 32'h55, "t4_a_next");
    push(2, 32'h55, "t4_b_next");
    cycle();

    // Address boundaries: out-of-range on B, top register on both.
    set_a(1, 31, 32'hA5A5A5A5, 0, 0);
    set_b(1, 30, 32'h00000BAD, 0, 0);
    cycle();
    set_a(0, 0, 0, 31, 0);
    set_b(0, 0, 0, 30, 5);
    push(7, 32'h1, "t5_b_err_pulse");
    push(5, 32'h0, "t5_a_no_err");
    push(0, 32'hA5A5A5A5, "t5_a_r31");
    push(2, 32'h0, "t5_b_rd30");
    push(3, 32'hCAFEF00D, "t5_b_r5_kept");
    cycle();
    set_b(1, 23, 32'h00002323, 14, 6);
    push(7, 32'h0, "t5_b_err_one_cycle");
    push(2, 32'h0, "t5_b_r14_untouched");
    push(3, 32'h0, "t5_b_r6_untouched");
    cycle();
    set_b(0, 0, 0, 23, 24);
    push(7, 32'h0, "t5_b_r23_no_err");
    push(2, 32'h00002323, "t5_b_r23");
    push(3, 32'h0, "t5_b_rd24");
    cycle();

    // Reset during ready and during clear.
    set_a(1, 3, 32'h9, 0, 0);
    set_b(1, 3, 32'h9, 0, 0);
    cycle();
    set_a(0, 0, 0, 3, 0);
    set_b(0, 0, 0, 3, 0);
    push(0, 32'h9, "t6_a_r3_before");
    push(2, 32'h9, "t6_b_r3_before");
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_a(1, 3, 32'h77, 3, 5);
      set_b(1, 3, 32'h77, 3, 5);
      if (i > 0) push(5, 32'h1, "t6_a_err_in_clear");
      if (i > 0) push(7, 32'h1, "t6_b_err_in_clear");
      push(0, 32'h0, "t6_a_rd_in_clear");
      cycle();
    end
    set_a(0, 0, 0, 3, 5);
    set_b(0, 0, 0, 3, 5);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      push(4, 32'h0, "t6_a_ready_low");
      cycle();
    end
    push(4, 32'h1, "t6_a_ready");
    push(6, 32'h1, "t6_b_ready");
    push(0, 32'h0, "t6_a_r3_cleared");
    push(1, 32'h0, "t6_a_r5_cleared");
    push(2, 32'h0, "t6_b_r3_cleared");
    push(3, 32'h0, "t6_b_r5_cleared");
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
